// File: rtl/irq_pkg.sv
// irq_arbiter shared constants: register offsets, FSM encoding, STATUS fields.
// Optional service watchdog is enabled with IRQ_TIMEOUT_EN.
package irq_pkg;

  localparam int ID_W = 3;

  localparam logic [1:0] OFF_MASK   = 2'd0;
  localparam logic [1:0] OFF_MODE   = 2'd1;
  localparam logic [1:0] OFF_PEND   = 2'd2;
  localparam logic [1:0] OFF_STATUS = 2'd3;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_ACTIVE = 2'd1;
  localparam logic [1:0] ST_GAP    = 2'd2;

  localparam int STAT_ACT = 31;
  localparam int STAT_ERR = 30;

endpackage

// File: rtl/irq_prio_enc.sv
// Lowest-index-wins priority encoder for the request vector.
// Purely combinational; valid is low when no bit is set.
module irq_prio_enc
  import irq_pkg::*;
#(
  parameter int N = 6
) (
  input  logic [N-1:0]    req,
  output logic [ID_W-1:0] id,
  output logic            valid
);

  always_comb begin
    id    = '0;
    valid = 1'b0;
    for (int i = N - 1; i >= 0; i--) begin
      if (req[i]) begin
        id    = ID_W'(i);
        valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/irq_arbiter.sv
// Memory-mapped interrupt arbiter: MASK/MODE/PEND/STATUS, one-hot hwint.
// Define IRQ_TIMEOUT_EN to add the service watchdog and sticky err bit.
module irq_arbiter
  import irq_pkg::*;
#(
  parameter int N_SRC   = 6,
  parameter int TIMEOUT = 1024
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [N_SRC-1:0] src_irq,
  input  logic [31:0]      Addr,
  input  logic             WE,
  input  logic [31:0]      Din,
  output logic [31:0]      Dout,
  output logic [N_SRC-1:0] hwint
);

  logic [N_SRC-1:0] src_q;
  logic [N_SRC-1:0] src_qq;
  logic [N_SRC-1:0] pend_e;
  logic [N_SRC-1:0] pend_e_nxt;
  logic [N_SRC-1:0] mask;
  logic [N_SRC-1:0] mode;
  logic [N_SRC-1:0] pend;
  logic [N_SRC-1:0] req;
  logic [N_SRC-1:0] rise;
  logic [N_SRC-1:0] clr;
  logic [N_SRC-1:0] one;
  logic [N_SRC-1:0] cur_oh;

  logic [1:0]      state;
  logic [1:0]      reg_sel;
  logic [ID_W-1:0] cur_id;
  logic [ID_W-1:0] win_id;
  logic            win_vld;
  logic            err;
  logic            to_hit;

  logic wr_mask;
  logic wr_mode;
  logic wr_pend;
  logic wr_stat;
  logic eoi;
  logic done;

  assign reg_sel = Addr[3:2];
  assign wr_mask = WE && (reg_sel == OFF_MASK);
  assign wr_mode = WE && (reg_sel == OFF_MODE);
  assign wr_pend = WE && (reg_sel == OFF_PEND);
  assign wr_stat = WE && (reg_sel == OFF_STATUS);

  assign eoi  = wr_stat && (state == ST_ACTIVE);
  assign done = eoi || to_hit;

  assign one    = N_SRC'(1);
  assign cur_oh = one << cur_id;

  // Level bits track the synchroniser; edge bits are latched.
  assign pend = (mode & pend_e) | (~mode & src_q);
  assign req  = pend & mask;
  assign rise = src_q & ~src_qq;

  assign clr = ({N_SRC{wr_pend}} & Din[N_SRC-1:0])
             | ({N_SRC{done}} & cur_oh);

  // A new edge beats any clear in the same cycle.
  assign pend_e_nxt = ((pend_e & ~clr) | rise) & mode;

  irq_prio_enc #(
    .N (N_SRC)
  ) u_enc (
    .req   (req),
    .id    (win_id),
    .valid (win_vld)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      src_q  <= '0;
      src_qq <= '0;
      pend_e <= '0;
      mask   <= '0;
      mode   <= '0;
    end else begin
      src_q  <= src_irq;
      src_qq <= src_q;
      pend_e <= pend_e_nxt;
      if (wr_mask) mask <= Din[N_SRC-1:0];
      if (wr_mode) mode <= Din[N_SRC-1:0];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= ST_IDLE;
      cur_id <= '0;
      hwint  <= '0;
    end else begin
      unique case (state)
        ST_IDLE: begin
          if (win_vld) begin
            cur_id <= win_id;
            hwint  <= one << win_id;
            state  <= ST_ACTIVE;
          end
        end
        ST_ACTIVE: begin
          if (done) begin
            hwint <= '0;
            state <= ST_GAP;
          end
        end
        ST_GAP:  state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

`ifdef IRQ_TIMEOUT_EN
  logic [15:0] cnt;

  assign to_hit = (state == ST_ACTIVE) && !wr_stat
               && (cnt == 16'(TIMEOUT - 1));

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt <= '0;
      err <= 1'b0;
    end else begin
      if (state != ST_ACTIVE || done) cnt <= '0;
      else                            cnt <= cnt + 16'd1;
      if (to_hit)
        err <= 1'b1;
      else if (wr_stat && Din[STAT_ERR])
        err <= 1'b0;
    end
  end
`else
  assign to_hit = 1'b0;
  assign err    = 1'b0;
`endif

  always_comb begin
    Dout = '0;
    unique case (reg_sel)
      OFF_MASK: Dout[N_SRC-1:0] = mask;
      OFF_MODE: Dout[N_SRC-1:0] = mode;
      OFF_PEND: Dout[N_SRC-1:0] = pend;
      default: begin
        Dout[STAT_ACT]   = (state == ST_ACTIVE);
        Dout[STAT_ERR]   = err;
        Dout[ID_W-1:0]   = cur_id;
      end
    endcase
  end

  logic unused_ok;
  assign unused_ok = ^{Addr[31:4], Addr[1:0], Din, 32'(TIMEOUT)};

endmodule

// File: tb/tb_irq_arbiter.sv
// Directed + random bench for irq_arbiter against a per-source reference model.
// Timeout steps are compiled in when IRQ_TIMEOUT_EN is defined.
module tb_irq_arbiter;

  localparam int N  = 6;
  localparam int TO = 8;

  logic          clk = 1'b0;
  logic          reset;
  logic [N-1:0]  src_irq;
  logic [31:0]   Addr;
  logic          WE;
  logic [31:0]   Din;
  logic [31:0]   Dout;
  logic [N-1:0]  hwint;

  int tests = 0;
  int fails = 0;

  irq_arbiter #(
    .N_SRC   (N),
    .TIMEOUT (TO)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .src_irq (src_irq),
    .Addr    (Addr),
    .WE      (WE),
    .Din     (Din),
    .Dout    (Dout),
    .hwint   (hwint)
  );

  always #5 clk = ~clk;

  // Reference model: per-source bits, phase 0=idle 1=serving 2=gap.
  bit m_q  [N];
  bit m_qq [N];
  bit m_pe [N];
  bit m_msk[N];
  bit m_mod[N];
  int m_phase;
  int m_cur;
  int m_cnt;
  bit m_err;

  function automatic bit m_pend_bit(int i);
    return m_mod[i] ? m_pe[i] : m_q[i];
  endfunction

  function automatic logic [31:0] m_vec(int sel);
    logic [31:0] r;
    r = '0;
    for (int i = 0; i < N; i++) begin
      case (sel)
        0:       r[i] = m_msk[i];
        1:       r[i] = m_mod[i];
        default: r[i] = m_pend_bit(i);
      endcase
    end
    return r;
  endfunction

  function automatic logic [31:0] m_read(int a);
    logic [31:0] r;
    if (a < 3) return m_vec(a);
    r = '0;
    r[31] = (m_phase == 1);
    r[30] = m_err;
    r[2:0] = 3'(m_cur);
    return r;
  endfunction

  function automatic logic [31:0] m_hw();
    logic [31:0] r;
    r = '0;
    if (m_phase == 1) r[m_cur] = 1'b1;
    return r;
  endfunction

  task automatic m_step();
    int  a;
    int  win;
    bit  eoi;
    bit  to;
    bit  np[N];
    if (reset) begin
      for (int i = 0; i < N; i++) begin
        m_q[i] = 0; m_qq[i] = 0; m_pe[i] = 0;
        m_msk[i] = 0; m_mod[i] = 0;
      end
      m_phase = 0; m_cur = 0; m_cnt = 0; m_err = 0;
      return;
    end
    a   = int'(Addr[3:2]);
    eoi = WE && a == 3 && m_phase == 1;
    to  = 0;
`ifdef IRQ_TIMEOUT_EN
    if (m_phase == 1 && !eoi) begin
      if (m_cnt == TO - 1) to = 1;
      else m_cnt++;
    end
`endif
    for (int i = 0; i < N; i++) begin
      bit keep;
      keep = m_pe[i] && !(WE && a == 2 && Din[i])
          && !((eoi || to) && m_cur == i);
      np[i] = m_mod[i] && (keep || (m_q[i] && !m_qq[i]));
    end
    case (m_phase)
      0: begin
        win = -1;
        for (int i = N - 1; i >= 0; i--)
          if (m_pend_bit(i) && m_msk[i]) win = i;
        if (win >= 0) begin
          m_cur = win; m_phase = 1; m_cnt = 0;
        end
      end
      1: if (eoi || to) m_phase = 2;
      default: m_phase = 0;
    endcase
`ifdef IRQ_TIMEOUT_EN
    m_err = (m_err && !(WE && a == 3 && Din[30])) || to;
`endif
    for (int i = 0; i < N; i++) begin
      if (WE && a == 0) m_msk[i] = Din[i];
      if (WE && a == 1) m_mod[i] = Din[i];
      m_pe[i] = np[i];
      m_qq[i] = m_q[i];
      m_q[i]  = src_irq[i];
    end
  endtask

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick(input logic [N-1:0] s, input logic we,
                      input logic [1:0] a, input logic [31:0] d);
    src_irq = s;
    WE      = we;
    Addr    = {28'd0, a, 2'b00};
    Din     = d;
    m_step();
    @(posedge clk);
    #1;
    WE = 1'b0;
    chk("hwint_model", 32'(hwint), m_hw());
  endtask

  task automatic idle(input logic [N-1:0] s, input int n);
    for (int i = 0; i < n; i++) tick(s, 1'b0, 2'd0, 32'd0);
  endtask

  task automatic rdc(string tag, input logic [1:0] a,
                     input logic [31:0] exp);
    WE   = 1'b0;
    Addr = {28'd0, a, 2'b00};
    #1;
    chk(tag, Dout, exp);
    chk({tag, "_model"}, Dout, m_read(int'(a)));
  endtask

  task automatic hwc(string tag, input logic [N-1:0] exp);
    chk(tag, 32'(hwint), 32'(exp));
  endtask

  initial begin
    reset = 1'b1;
    WE = 1'b0; Addr = '0; Din = '0;
    tick(6'h3F, 0, 0, 0);
    tick(6'h3F, 0, 0, 0);
    for (int a = 0; a < 4; a++) rdc("rst_rd", 2'(a), 32'd0);
    hwc("rst_hw", 6'h00);
    reset = 1'b0;

    // level, single source
    tick(6'h00, 1, 2'd0, 32'h3F);
    tick(6'h00, 1, 2'd1, 32'h00);
    tick(6'h02, 0, 0, 0);
    tick(6'h02, 0, 0, 0);
    hwc("lvl_hw", 6'b000010);
    rdc("lvl_stat", 2'd3, 32'h8000_0001);
    tick(6'h02, 1, 2'd3, 0);
    hwc("lvl_gap", 6'h00);
    idle(6'h02, 2);
    hwc("lvl_reserve", 6'b000010);
    tick(6'h00, 1, 2'd3, 0);
    idle(6'h00, 3);
    hwc("lvl_done", 6'h00);

    // edge priority
    tick(6'h00, 1, 2'd1, 32'h3F);
    idle(6'h0C, 2);
    rdc("pri_pend", 2'd2, 32'h0C);
    tick(6'h0C, 0, 0, 0);
    hwc("pri_hw2", 6'b000100);
    rdc("pri_stat", 2'd3, 32'h8000_0002);
    tick(6'h0C, 1, 2'd3, 0);
    rdc("pri_pend2", 2'd2, 32'h08);
    idle(6'h0C, 2);
    hwc("pri_hw3", 6'b001000);
    tick(6'h0C, 1, 2'd3, 0);
    rdc("pri_pend3", 2'd2, 32'h00);
    idle(6'h0C, 3);
    hwc("pri_idle", 6'h00);

    // edge / EOI collision on src 0
    idle(6'h00, 2);
    idle(6'h01, 3);
    hwc("col_hw", 6'b000001);
    idle(6'h00, 2);
    tick(6'h01, 0, 0, 0);
    tick(6'h01, 1, 2'd3, 0);
    rdc("col_pend", 2'd2, 32'h01);
    idle(6'h01, 2);
    hwc("col_reserve", 6'b000001);
    tick(6'h01, 1, 2'd3, 0);
    idle(6'h00, 3);
    rdc("col_clr", 2'd2, 32'h00);

    // masked source, then unmask
    tick(6'h00, 1, 2'd0, 32'h2F);
    idle(6'h10, 3);
    hwc("msk_hw", 6'h00);
    rdc("msk_pend", 2'd2, 32'h10);
    tick(6'h10, 1, 2'd0, 32'h3F);
    tick(6'h10, 0, 0, 0);
    hwc("msk_unmask", 6'b010000);
    tick(6'h10, 1, 2'd3, 0);
    idle(6'h10, 3);

    // W1C before unmask: never served
    tick(6'h00, 1, 2'd0, 32'h2F);
    idle(6'h00, 2);
    idle(6'h10, 2);
    rdc("w1c_pend", 2'd2, 32'h10);
    tick(6'h10, 1, 2'd2, 32'h10);
    rdc("w1c_clr", 2'd2, 32'h00);
    tick(6'h10, 1, 2'd0, 32'h3F);
    idle(6'h10, 3);
    hwc("w1c_hw", 6'h00);

    // src 2 in service without EOI
    idle(6'h14, 3);
    hwc("to_hw", 6'b000100);
`ifdef IRQ_TIMEOUT_EN
    for (int i = 0; i < TO - 1; i++) begin
      tick(6'h14, 0, 0, 0);
      hwc("to_hold", 6'b000100);
    end
    tick(6'h14, 0, 0, 0);
    hwc("to_drop", 6'h00);
    rdc("to_err", 2'd3, 32'h4000_0002);
    tick(6'h14, 1, 2'd3, 32'h4000_0000);
    rdc("to_errclr", 2'd3, 32'h0000_0002);
`else
    idle(6'h14, 20);
    hwc("nto_hold", 6'b000100);
    rdc("nto_stat", 2'd3, 32'h8000_0002);
    tick(6'h14, 1, 2'd3, 0);
`endif
    idle(6'h14, 3);

    // reset during service
    tick(6'h14, 1, 2'd1, 32'h00);
    tick(6'h14, 0, 0, 0);
    hwc("rstact_pre", 6'b000100);
    reset = 1'b1;
    tick(6'h14, 0, 0, 0);
    hwc("rstact_hw", 6'h00);
    reset = 1'b0;

    // random traffic against the model
    for (int n = 0; n < 3000; n++) begin
      logic [N-1:0] s;
      s = src_irq;
      if ($urandom_range(2) == 0) s = N'($urandom);
      reset = ($urandom_range(599) == 0);
      tick(s, ($urandom_range(3) == 0), 2'($urandom),
           $urandom);
      reset = 1'b0;
      WE   = 1'b0;
      Addr = {28'd0, 2'($urandom), 2'b00};
      #1;
      chk("rnd_rd", Dout, m_read(int'(Addr[3:2])));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
